gps_result_buf: RTL and testbench

GPS_RESULT_BUF -- requirements
Module: gps_result_buf

---
 rtl/gps_result_buf.sv | 138 +++++++++++++
 tb/tb_gps_result_buf.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gps_result_buf.sv
// rtl/gps_result_buf.sv - buffers GPS code-generator results and streams them out as 32-bit words
module gps_result_buf #(
   parameter int DEPTH = 4
) (
   input  logic                     sys_clk_50,
   input  logic                     sync_rst_in,
   input  logic [5:0]               sv_num,
   input  logic [12:0]              ca_code,
   input  logic [127:0]             p_code,
   input  logic [127:0]             l_code,
   input  logic                     l_code_valid,
   input  logic                     rd_req,
   output logic [31:0]              rd_data,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 6 + 13 + 128 + 128;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state;
   logic [3:0]      idx;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic            lcv_q;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   head_ent;
   logic            capture;
   logic            pop;
   logic            accept;
   logic            drop;

   // Entry layout: [274:269] sv_num, [268:256] ca_code, [255:128] p_code, [127:0] l_code
   function automatic logic [31:0] word_sel(input logic [3:0] i, input logic [EW-1:0] e);
      logic [31:0] w;
      case (i)
         4'd0:    w = {13'b0, e[274:256]};
         4'd1:    w = e[255:224];
         4'd2:    w = e[223:192];
         4'd3:    w = e[191:160];
         4'd4:    w = e[159:128];
         4'd5:    w = e[127:96];
         4'd6:    w = e[95:64];
         4'd7:    w = e[63:32];
         4'd8:    w = e[31:0];
         default: w = 32'b0;
      endcase
      return w;
   endfunction

   assign empty    = (count == '0);
   assign full     = (count == DEPTH_C);
   assign capture  = l_code_valid & ~lcv_q;
   assign pop      = (state == SEND) && (idx == 4'd8);
   // A pop in the same cycle frees the head slot, so a capture into a full buffer is still accepted
   assign accept   = capture & (~full | pop);
   assign drop     = capture & full & ~pop;
   assign head_ent = mem[head];

   // Entry storage; when full, tail equals head and is only rewritten on the word-8 (pop) cycle
   always_ff @(posedge sys_clk_50) begin
      if (!sync_rst_in && accept) begin
         mem[tail] <= {sv_num, ca_code, p_code, l_code};
      end
   end

   // Control: edge detect, pointers, occupancy, overflow flag and readout FSM
   always_ff @(posedge sys_clk_50) begin
      if (sync_rst_in) begin
         state    <= IDLE;
         idx      <= 4'd0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= 32'b0;
         lcv_q    <= 1'b0;
      end else begin
         lcv_q <= l_code_valid;

         if (accept) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end

         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rd_req && !empty) begin
                  state    <= SEND;
                  idx      <= 4'd0;
                  rd_valid <= 1'b1;
                  rd_data  <= word_sel(4'd0, head_ent);
               end
            end
            SEND: begin
               if (idx == 4'd8) begin
                  state    <= IDLE;
                  idx      <= 4'd0;
                  rd_valid <= 1'b0;
                  rd_data  <= 32'b0;
               end else begin
                  idx      <= idx + 4'd1;
                  rd_data  <= word_sel(idx + 4'd1, head_ent);
               end
            end
            default: begin
               state    <= IDLE;
               idx      <= 4'd0;
               rd_valid <= 1'b0;
               rd_data  <= 32'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gps_result_buf.sv
// tb/tb_gps_result_buf.sv - directed self-checking bench for gps_result_buf
module tb_gps_result_buf;

   logic          sys_clk_50 = 1'b0;
   logic          sync_rst_in;
   logic [5:0]    sv_num;
   logic [12:0]   ca_code;
   logic [127:0]  p_code;
   logic [127:0]  l_code;
   logic          l_code_valid;
   logic          rd_req;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [2:0]    count;
   logic          overflow;
   logic          clr_overflow;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_w [9];

   gps_result_buf #(.DEPTH(4)) dut (
      .sys_clk_50   (sys_clk_50),
      .sync_rst_in  (sync_rst_in),
      .sv_num       (sv_num),
      .ca_code      (ca_code),
      .p_code       (p_code),
      .l_code       (l_code),
      .l_code_valid (l_code_valid),
      .rd_req       (rd_req),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 sys_clk_50 = ~sys_clk_50;

   task automatic tick();
      @(negedge sys_clk_50);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Tagged entry: ca = {7'h01, sv}, p words = {k, 22'h0, sv} for k=1..4, l words for k=5..8
   task automatic set_entry(input logic [5:0] sv);
      sv_num  = sv;
      ca_code = {7'h01, sv};
      p_code  = {4'd1, 22'h0, sv, 4'd2, 22'h0, sv, 4'd3, 22'h0, sv, 4'd4, 22'h0, sv};
      l_code  = {4'd5, 22'h0, sv, 4'd6, 22'h0, sv, 4'd7, 22'h0, sv, 4'd8, 22'h0, sv};
   endtask

   task automatic set_exp(input logic [5:0] sv);
      exp_w[0] = {13'b0, sv, 7'h01, sv};
      for (int k = 1; k <= 8; k++) begin
         exp_w[k] = {4'(k), 22'h0, sv};
      end
   endtask

   task automatic pulse_capture(input logic [5:0] sv);
      set_entry(sv);
      l_code_valid = 1'b1;
      tick();
      l_code_valid = 1'b0;
      tick();
   endtask

   // Reads one entry against exp_w; optionally raises a capture of cap_sv on the word-8 cycle
   task automatic read_entry(input string tag, input bit cap8, input logic [5:0] cap_sv);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      for (int w = 0; w < 9; w++) begin
         check($sformatf("%s_valid%0d", tag, w), {31'b0, rd_valid}, 32'd1);
         check($sformatf("%s_word%0d", tag, w), rd_data, exp_w[w]);
         if (w == 8 && cap8) begin
            set_entry(cap_sv);
            l_code_valid = 1'b1;
         end
         tick();
      end
      l_code_valid = 1'b0;
      check({tag, "_valid_end"}, {31'b0, rd_valid}, 32'd0);
      check({tag, "_data_end"}, rd_data, 32'd0);
   endtask

   initial begin
      sync_rst_in  = 1'b1;
      l_code_valid = 1'b0;
      rd_req       = 1'b0;
      clr_overflow = 1'b0;
      set_entry(6'd0);
      repeat (3) tick();

      check("rst_valid", {31'b0, rd_valid}, 32'd0);
      check("rst_data", rd_data, 32'd0);
      check("rst_count", {29'b0, count}, 32'd0);
      check("rst_empty", {31'b0, empty}, 32'd1);
      check("rst_full", {31'b0, full}, 32'd0);
      check("rst_ovf", {31'b0, overflow}, 32'd0);
      sync_rst_in = 1'b0;
      tick();

      // Single capture and readout
      sv_num  = 6'd5;
      ca_code = 13'h1ABC;
      p_code  = 128'h0123456789ABCDEF0123456789ABCDEF;
      l_code  = 128'hFEDCBA9876543210FEDCBA9876543210;
      l_code_valid = 1'b1;
      tick();
      l_code_valid = 1'b0;
      check("single_count1", {29'b0, count}, 32'd1);
      tick();
      exp_w[0] = 32'h0000BABC;
      exp_w[1] = 32'h01234567;
      exp_w[2] = 32'h89ABCDEF;
      exp_w[3] = 32'h01234567;
      exp_w[4] = 32'h89ABCDEF;
      exp_w[5] = 32'hFEDCBA98;
      exp_w[6] = 32'h76543210;
      exp_w[7] = 32'hFEDCBA98;
      exp_w[8] = 32'h76543210;
      read_entry("single", 1'b0, 6'd0);
      check("single_count0", {29'b0, count}, 32'd0);

      // Held level gives one capture
      set_entry(6'd7);
      l_code_valid = 1'b1;
      repeat (20) tick();
      l_code_valid = 1'b0;
      tick();
      check("held_count", {29'b0, count}, 32'd1);
      set_exp(6'd7);
      read_entry("held", 1'b0, 6'd0);
      check("held_empty", {31'b0, empty}, 32'd1);

      // Overflow on fifth capture
      for (int i = 0; i < 5; i++) begin
         pulse_capture(6'(10 + i));
      end
      check("ovf_full", {31'b0, full}, 32'd1);
      check("ovf_count", {29'b0, count}, 32'd4);
      check("ovf_flag", {31'b0, overflow}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         set_exp(6'(10 + i));
         read_entry($sformatf("ovf_rd%0d", i), 1'b0, 6'd0);
      end
      check("ovf_drained", {31'b0, empty}, 32'd1);
      check("ovf_sticky", {31'b0, overflow}, 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("ovf_cleared", {31'b0, overflow}, 32'd0);

      // Capture on the pop cycle of a full buffer
      for (int i = 0; i < 4; i++) begin
         pulse_capture(6'(20 + i));
      end
      check("cop_full", {31'b0, full}, 32'd1);
      set_exp(6'd20);
      read_entry("cop_rd0", 1'b1, 6'd24);
      check("cop_count", {29'b0, count}, 32'd4);
      check("cop_noovf", {31'b0, overflow}, 32'd0);
      for (int i = 1; i < 5; i++) begin
         set_exp(6'(20 + i));
         read_entry($sformatf("cop_rd%0d", i), 1'b0, 6'd0);
      end
      check("cop_empty", {31'b0, empty}, 32'd1);

      // Reset during word 3
      pulse_capture(6'd30);
      pulse_capture(6'd31);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      repeat (3) tick();
      check("rstmid_word3", rd_data, 32'h3000001E);
      sync_rst_in = 1'b1;
      tick();
      check("rstmid_valid", {31'b0, rd_valid}, 32'd0);
      check("rstmid_count", {29'b0, count}, 32'd0);
      check("rstmid_empty", {31'b0, empty}, 32'd1);
      sync_rst_in = 1'b0;
      tick();
      check("rstmid_valid2", {31'b0, rd_valid}, 32'd0);

      // Read request while empty
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("emptyrd_valid%0d", i), {31'b0, rd_valid}, 32'd0);
      end
      rd_req = 1'b0;
      tick();
      check("emptyrd_valid_after", {31'b0, rd_valid}, 32'd0);
      check("emptyrd_count", {29'b0, count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
